// File: rtl/dac_word_sequencer_if.sv
// ---------------------------------------------------------------------------
// dac_word_sequencer_if
// Word-push handshake between dac_word_sequencer and the daisy-chain DAC
// serializer.
//   prog          seq -> ser  one-cycle word-push strobe ("program" is a
//                             SystemVerilog keyword, so the wire is named prog)
//   ep_din[31:0]  seq -> ser  daisy word, stable while prog is high
//   update        seq -> ser  frame-commit level
//   fifo_full     ser -> seq  serializer FIFO cannot take a word
//   fifo_wr_done  ser -> seq  serializer write-complete level
// Modports: master = sequencer side, slave = serializer side.
// ---------------------------------------------------------------------------
interface dac_word_sequencer_if;
    logic        prog;
    logic [31:0] ep_din;
    logic        update;
    logic        fifo_full;
    logic        fifo_wr_done;

    modport master (output prog, ep_din, update, input fifo_full, fifo_wr_done);
    modport slave  (input prog, ep_din, update, output fifo_full, fifo_wr_done);
endinterface

// File: rtl/dac_word_sequencer.sv
// ---------------------------------------------------------------------------
// dac_word_sequencer
// Holds an N_DEV x N_CH table of 16-bit DAC codes and, on start, pushes one
// frame per channel to the daisy-chain serializer. A frame is one 32-bit word
// per device, farthest device (N_DEV-1) first, followed by an UPDATE_HOLD-cycle
// update window so the serializer commits the frame.
// Word: {8'h00, cmd[3:0], ch[3:0], code[15:0]}.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_we/dev/ch/data  table write port, accepted in every state
//   start               one-cycle pulse, ignored while busy
//   busy, done, err     sequence status; err is a sticky handshake timeout
//   ser                 serializer handshake (dac_word_sequencer_if.master)
// Optional feature macro DAC_SEQ_DIRTY_EN: per-entry dirty bits; channels
// with no dirty device are skipped and clean devices get CMD_NOP.
// ---------------------------------------------------------------------------
module dac_word_sequencer #(
    parameter int         N_DEV       = 2,
    parameter int         DEV_W       = 1,
    parameter int         N_CH        = 8,
    parameter logic [3:0] CMD_WR      = 4'h3,
    parameter logic [3:0] CMD_NOP     = 4'hF,
    parameter int         UPDATE_HOLD = 1024,
    parameter int         HS_TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [DEV_W-1:0] cfg_dev,
    input  logic [3:0]       cfg_ch,
    input  logic [15:0]      cfg_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    dac_word_sequencer_if.master ser
);
    localparam int N_ENT  = N_DEV * N_CH;
    localparam int IDX_W  = (N_ENT > 1) ? $clog2(N_ENT) : 1;
    localparam int HOLD_W = (UPDATE_HOLD > 1) ? $clog2(UPDATE_HOLD) : 1;
    localparam int TO_W   = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(UPDATE_HOLD - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(HS_TIMEOUT - 1);
    localparam logic [DEV_W-1:0]  DEV_MAX   = DEV_W'(N_DEV - 1);

    typedef enum logic [2:0] {IDLE, LOAD, PUSH, WAIT_LO, WAIT_HI, HOLD, FIN} state_t;

    state_t             state_q, state_d;
    logic [DEV_W-1:0]   dev_q, dev_d;
    logic [3:0]         ch_q, ch_d;
    logic [31:0]        ep_din_q, ep_din_d;
    logic               prog_q, prog_d;
    logic               update_q, update_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TO_W-1:0]    to_q, to_d;

    logic [15:0]        tbl_q [N_ENT];
    logic [IDX_W-1:0]   rd_idx;
    logic [N_CH-1:0]    ch_dirty;
    logic               entry_dirty;
    logic [3:0]         word_cmd;
    logic               nxt_found;
    logic [3:0]         nxt_ch;
    int                 from_ch;

    // Flattened table: entry gi holds device gi/N_CH, channel gi%N_CH.
    // Out-of-range cfg_dev/cfg_ch never match any entry, so they are dropped.
`ifdef DAC_SEQ_DIRTY_EN
    logic dirty_q [N_ENT];
    logic hold_done;
    assign hold_done = (state_q == HOLD) && (hold_q == HOLD_LAST);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_ENT; gi++) begin : g_ent
            localparam int DEV = gi / N_CH;
            localparam int CH  = gi % N_CH;
            logic        wr_hit;
            logic [15:0] ent_d;

            assign wr_hit = cfg_we && (cfg_dev == DEV_W'(DEV)) && (cfg_ch == 4'(CH));

            always_comb begin
                ent_d = wr_hit ? cfg_data : tbl_q[gi];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) tbl_q[gi] <= '0;
                else     tbl_q[gi] <= ent_d;
            end
`ifdef DAC_SEQ_DIRTY_EN
            // A write in the same cycle as the channel's HOLD completion wins.
            logic dirty_d;
            always_comb begin
                dirty_d = wr_hit | (dirty_q[gi] & ~(hold_done && (ch_q == 4'(CH))));
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) dirty_q[gi] <= 1'b1;
                else     dirty_q[gi] <= dirty_d;
            end
`endif
        end
    endgenerate

    assign rd_idx = IDX_W'(int'(dev_q) * N_CH + int'(ch_q));

`ifdef DAC_SEQ_DIRTY_EN
    always_comb begin
        ch_dirty = '0;
        for (int c = 0; c < N_CH; c++)
            for (int d = 0; d < N_DEV; d++)
                if (dirty_q[d * N_CH + c]) ch_dirty[c] = 1'b1;
    end
    assign entry_dirty = dirty_q[rd_idx];
`else
    assign ch_dirty    = '1;
    assign entry_dirty = 1'b1;
`endif

    assign word_cmd = entry_dirty ? CMD_WR : CMD_NOP;

    // Lowest channel at or above the candidate that has something to send.
    // From IDLE the candidate is channel 0, otherwise the one after ch_q.
    always_comb begin
        from_ch   = (state_q == IDLE) ? 0 : int'(ch_q) + 1;
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (c >= from_ch && ch_dirty[c]) begin
                nxt_found = 1'b1;
                nxt_ch    = 4'(c);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dev_d    = dev_q;
        ch_d     = ch_q;
        ep_din_d = ep_din_q;
        prog_d   = 1'b0;
        update_d = update_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        hold_d   = hold_q;
        to_d     = to_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    if (nxt_found) begin
                        ch_d    = nxt_ch;
                        dev_d   = DEV_MAX;
                        state_d = LOAD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            LOAD: begin
                ep_din_d = {8'h00, word_cmd, ch_q, tbl_q[rd_idx]};
                state_d  = PUSH;
            end
            PUSH: begin
                if (!ser.fifo_full) begin
                    prog_d  = 1'b1;
                    to_d    = '0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!ser.fifo_wr_done) begin
                    to_d    = '0;
                    state_d = WAIT_HI;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            WAIT_HI: begin
                if (ser.fifo_wr_done) begin
                    if (dev_q != '0) begin
                        dev_d   = dev_q - 1'b1;
                        state_d = LOAD;
                    end else begin
                        hold_d   = '0;
                        update_d = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    update_d = 1'b0;
                    if (nxt_found) begin
                        ch_d    = nxt_ch;
                        dev_d   = DEV_MAX;
                        state_d = LOAD;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dev_q    <= '0;
            ch_q     <= '0;
            ep_din_q <= '0;
            prog_q   <= 1'b0;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= '0;
            to_q     <= '0;
        end else begin
            state_q  <= state_d;
            dev_q    <= dev_d;
            ch_q     <= ch_d;
            ep_din_q <= ep_din_d;
            prog_q   <= prog_d;
            update_q <= update_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
            to_q     <= to_d;
        end
    end

    assign ser.prog   = prog_q;
    assign ser.ep_din = ep_din_q;
    assign ser.update = update_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_dac_word_sequencer.sv
module tb_dac_word_sequencer;
    localparam int N_DEV = 2;
    localparam int DEV_W = 1;
    localparam int N_CH  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [DEV_W-1:0] cfg_dev = '0;
    logic [3:0]       cfg_ch = '0;
    logic [15:0]      cfg_data = '0;
    logic             start = 1'b0;
    logic             busy, done, err;

    dac_word_sequencer_if ifc();

    dac_word_sequencer #(
        .N_DEV(N_DEV), .DEV_W(DEV_W), .N_CH(N_CH),
        .CMD_WR(4'h3), .CMD_NOP(4'hF), .UPDATE_HOLD(1024), .HS_TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_dev(cfg_dev), .cfg_ch(cfg_ch),
        .cfg_data(cfg_data), .start(start), .busy(busy), .done(done), .err(err),
        .ser(ifc.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Serializer model: drops fifo_wr_done after each push, raises it again a
    // few cycles later unless told to hang.
    logic stuck = 1'b0;
    int   ack_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            ifc.fifo_wr_done = 1'b1;
            ack_cnt = 0;
        end else if (ifc.prog) begin
            ifc.fifo_wr_done = 1'b0;
            ack_cnt = 3;
        end else if (ack_cnt > 0) begin
            ack_cnt--;
        end else if (!stuck) begin
            ifc.fifo_wr_done = 1'b1;
        end
    end

    // Observer: logs pushed words and update windows.
    int          prog_total = 0;
    int          upd_windows = 0;
    int          upd_len = 0;
    int          upd_last = 0;
    logic        upd_prev = 1'b0;
    logic [31:0] word_log [64];
    always @(negedge clk) begin
        if (ifc.prog) begin
            if (prog_total < 64) word_log[prog_total] = ifc.ep_din;
            prog_total++;
        end
        if (ifc.update) begin
            if (!upd_prev) upd_windows++;
            upd_len++;
        end else if (upd_prev) begin
            upd_last = upd_len;
            upd_len = 0;
        end
        upd_prev = ifc.update;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [DEV_W-1:0] d, input logic [3:0] c, input logic [15:0] v);
        tick();
        cfg_we = 1'b1; cfg_dev = d; cfg_ch = c; cfg_data = v;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic write_all();
        for (int d = 0; d < N_DEV; d++)
            for (int c = 0; c < N_CH; c++)
                write_cfg(DEV_W'(d), 4'(c), 16'(16'h1000 * (d + 1) + c));
    endtask

    // Returns one tick after the edge that samples start=1.
    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int n);
        n = 0;
        while (n < bound) begin
            tick();
            n++;
            if (done) break;
        end
        chk(tag, done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int p0, u0, n;

    initial begin
        ifc.fifo_full = 1'b0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_prog", ifc.prog, 1'b0);
        chk("rst_update", ifc.update, 1'b0);
        chk("rst_ep_din", ifc.ep_din, 32'h0);

        // Basic two-frame run
        write_cfg(1'b1, 4'd0, 16'h1234);
        write_cfg(1'b0, 4'd0, 16'hABCD);
        p0 = prog_total; u0 = upd_windows;
        pulse_start();
        chk("run_busy", busy, 1'b1);
        tick();
        chk("run_prog_early", ifc.prog, 1'b0);
        chk("run_first_word", ifc.ep_din, 32'h0030_1234);
        tick();
        chk("run_prog_latency", ifc.prog, 1'b1);
        wait_done("run_done", 3000, n);
        chk("run_busy_end", busy, 1'b0);
        chk("run_err", err, 1'b0);
        chk("run_prog_count", prog_total - p0, 4);
        chk("run_word0", word_log[p0], 32'h0030_1234);
        chk("run_word1", word_log[p0 + 1], 32'h0030_ABCD);
        chk("run_word2", word_log[p0 + 2], 32'h0031_0000);
        chk("run_word3", word_log[p0 + 3], 32'h0031_0000);
        chk("run_upd_windows", upd_windows - u0, 2);
        chk("run_upd_len", upd_last, 1024);
        tick();
        chk("run_done_pulse", done, 1'b0);

`ifdef DAC_SEQ_DIRTY_EN
        // Nothing dirty: the run is empty
        p0 = prog_total; u0 = upd_windows;
        pulse_start();
        wait_done("dirty_empty_done", 10, n);
        chk("dirty_empty_prog", prog_total - p0, 0);
        chk("dirty_empty_upd", upd_windows - u0, 0);
        // One dirty entry on channel 1
        write_cfg(1'b0, 4'd1, 16'h0F0F);
        p0 = prog_total; u0 = upd_windows;
        pulse_start();
        wait_done("dirty_one_done", 3000, n);
        chk("dirty_one_prog", prog_total - p0, 2);
        chk("dirty_word0", word_log[p0], 32'h00F1_0000);
        chk("dirty_word1", word_log[p0 + 1], 32'h0031_0F0F);
        chk("dirty_one_upd", upd_windows - u0, 1);
`endif

        // fifo_full back-pressure at the first push
        write_all();
        ifc.fifo_full = 1'b1;
        p0 = prog_total;
        pulse_start();
        repeat (50) tick();
        chk("full_no_prog", prog_total - p0, 0);
        ifc.fifo_full = 1'b0;
        tick();
        chk("full_prog_after_release", ifc.prog, 1'b1);
        wait_done("full_done", 3000, n);
        chk("full_err", err, 1'b0);
        chk("full_prog_count", prog_total - p0, 4);

        // WAIT_HI timeout
        write_all();
        stuck = 1'b1;
        p0 = prog_total; u0 = upd_windows;
        pulse_start();
        wait_done("to_done", 400, n);
        chk("to_latency", n, 259);
        chk("to_err", err, 1'b1);
        chk("to_upd", upd_windows - u0, 0);
        chk("to_prog_count", prog_total - p0, 1);
        stuck = 1'b0;
        repeat (5) tick();
        p0 = prog_total;
        pulse_start();
        chk("to_err_cleared", err, 1'b0);
        wait_done("to_rerun_done", 3000, n);
        chk("to_rerun_err", err, 1'b0);
        chk("to_rerun_prog", prog_total - p0, 4);

        // Reset in the middle of HOLD
        write_all();
        pulse_start();
        n = 0;
        while (n < 500 && !ifc.update) begin
            tick();
            n++;
        end
        chk("hold_reached", ifc.update, 1'b1);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        chk("abort_prog", ifc.prog, 1'b0);
        chk("abort_update", ifc.update, 1'b0);
        chk("abort_busy", busy, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();
        p0 = prog_total;
        pulse_start();
        tick();
        chk("replay_first_word", ifc.ep_din, 32'h0030_0000);
        wait_done("replay_done", 3000, n);
        chk("replay_prog_count", prog_total - p0, 4);
        chk("replay_word1", word_log[p0 + 1], 32'h0030_0000);
        chk("replay_word2", word_log[p0 + 2], 32'h0031_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
